// File: rtl/jk_bank_arbiter.sv
// Round-robin arbitrated controller for a bank of JK cells shared by two requesters.
// A three-state FSM applies one latched JK operation per grant and drives a hex 7-segment readout.
module jk_bank_arbiter #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [1:0]       op_a,
    input  logic [IDX_W-1:0] idx_a,
    input  logic             req_b,
    input  logic [1:0]       op_b,
    input  logic [IDX_W-1:0] idx_b,
    input  logic             clr_all,
    input  logic             set_all,
    output logic             ack_a,
    output logic             ack_b,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [6:0]       display7Segment
);

    typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

    localparam int NB = (WIDTH < 4) ? WIDTH : 4;

    state_t           state;
    logic             grantB;
    logic             lastGrantB;
    logic [1:0]       opReg;
    logic [IDX_W-1:0] idxReg;
    logic [WIDTH-1:0] applied;
    logic             inRange;
    logic             pickB;
    logic [3:0]       nibble;

    // On a tie the requester that did not win last time is favoured.
    assign pickB = req_b & (~req_a | ~lastGrantB);

    always_comb begin
        applied = q;
        inRange = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idxReg == IDX_W'(i)) begin
                inRange = 1'b1;
                case (opReg)
                    2'b10:   applied[i] = 1'b1;
                    2'b01:   applied[i] = 1'b0;
                    2'b11:   applied[i] = ~q[i];
                    default: applied[i] = q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grantB     <= 1'b0;
            lastGrantB <= 1'b1;
            opReg      <= 2'b00;
            idxReg     <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        grantB     <= pickB;
                        lastGrantB <= pickB;
                        opReg      <= pickB ? op_b : op_a;
                        idxReg     <= pickB ? idx_b : idx_a;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    ack_a <= ~grantB;
                    ack_b <= grantB;
                    err   <= ~inRange;
                    state <= ACK;
                end
                ACK: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bulk clear/preset win over the single-cell write landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr_all) begin
            q <= '0;
        end else if (set_all) begin
            q <= '1;
        end else if (state == APPLY) begin
            q <= applied;
        end
    end

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NB; i++) begin
            nibble[i] = q[i];
        end
    end

    always_comb begin
        case (nibble)
            4'h0:    display7Segment = 7'b1000000;
            4'h1:    display7Segment = 7'b1111001;
            4'h2:    display7Segment = 7'b0100100;
            4'h3:    display7Segment = 7'b0110000;
            4'h4:    display7Segment = 7'b0011001;
            4'h5:    display7Segment = 7'b0010010;
            4'h6:    display7Segment = 7'b0000010;
            4'h7:    display7Segment = 7'b1111000;
            4'h8:    display7Segment = 7'b0000000;
            4'h9:    display7Segment = 7'b0010000;
            4'hA:    display7Segment = 7'b0001000;
            4'hB:    display7Segment = 7'b0000011;
            4'hC:    display7Segment = 7'b1000110;
            4'hD:    display7Segment = 7'b0100001;
            4'hE:    display7Segment = 7'b0000110;
            default: display7Segment = 7'b0001110;
        endcase
    end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter; a WIDTH=3 copy shares the stimulus
// so out-of-range indices can be exercised.
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, clr_all, set_all;
    logic [1:0] op_a, op_b, idx_a, idx_b;
    logic       ack_a, ack_b, err, busy;
    logic [3:0] q;
    logic [6:0] disp;
    logic       ack_a3, ack_b3, err3, busy3;
    logic [2:0] q3;
    logic [6:0] disp3;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.WIDTH(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .idx_a(idx_a),
        .req_b(req_b), .op_b(op_b), .idx_b(idx_b),
        .clr_all(clr_all), .set_all(set_all),
        .ack_a(ack_a), .ack_b(ack_b), .err(err), .busy(busy),
        .q(q), .display7Segment(disp)
    );

    jk_bank_arbiter #(.WIDTH(3), .IDX_W(2)) dut3 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .idx_a(idx_a),
        .req_b(req_b), .op_b(op_b), .idx_b(idx_b),
        .clr_all(clr_all), .set_all(set_all),
        .ack_a(ack_a3), .ack_b(ack_b3), .err(err3), .busy(busy3),
        .q(q3), .display7Segment(disp3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_a = 0; req_b = 0; clr_all = 0; set_all = 0;
        op_a = 0; op_b = 0; idx_a = 0; idx_b = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        assertCount++;
        if ({q, busy, ack_a, ack_b, err} !== 8'b0000_0000) begin
            failCount++;
            $display("[TB] FAIL reset_state: got q=%b busy=%b ack=%b%b err=%b want all zero", q, busy, ack_a, ack_b, err);
        end
        set_all = 1'b1;
        tick();
        set_all = 1'b0;
        req_a = 1'b1; op_a = 2'b01; idx_a = 2'd1;
        tick();
        rst = 1'b1;
        req_a = 1'b0;
        #2;
        assertCount++;
        if ({q, busy, ack_a} !== 6'b0000_00) begin
            failCount++;
            $display("[TB] FAIL reset_mid_apply: got q=%b busy=%b ack_a=%b want 0000 0 0", q, busy, ack_a);
        end
        tick();
        rst = 1'b0;
        tick();
        assertCount++;
        if ({q, ack_a, busy} !== 6'b0000_00 || disp !== 7'b1000000) begin
            failCount++;
            $display("[TB] FAIL reset_release: got q=%b ack_a=%b busy=%b disp=%b want 0000 0 0 1000000", q, ack_a, busy, disp);
        end
    endtask

    task automatic test_single_op();
        req_a = 1'b1; op_a = 2'b10; idx_a = 2'd2;
        tick();
        assertCount++;
        if (busy !== 1'b1 || ack_a !== 1'b0 || q !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL single_e0: got busy=%b ack_a=%b q=%b want 1 0 0000", busy, ack_a, q);
        end
        tick();
        assertCount++;
        if (q !== 4'b0100 || ack_a !== 1'b1 || ack_b !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_e1: got q=%b ack=%b%b busy=%b err=%b want 0100 10 1 0", q, ack_a, ack_b, busy, err);
        end
        assertCount++;
        if (disp !== 7'b0011001) begin
            failCount++;
            $display("[TB] FAIL single_disp: got %b want 0011001", disp);
        end
        req_a = 1'b0;
        tick();
        assertCount++;
        if (ack_a !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_e2: got ack_a=%b busy=%b want 0 0", ack_a, busy);
        end
    endtask

    task automatic test_tie();
        logic [3:0] expQ [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0000};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 1'b1; op_a = 2'b11; idx_a = 2'd0;
        req_b = 1'b1; op_b = 2'b11; idx_b = 2'd1;
        for (int t = 0; t < 4; t++) begin
            tick();
            tick();
            assertCount++;
            if (ack_a !== (t % 2 == 0) || ack_b !== (t % 2 == 1) || q !== expQ[t]) begin
                failCount++;
                $display("[TB] FAIL tie_round%0d: got ack=%b%b q=%b want ack_a=%0d q=%b", t, ack_a, ack_b, q, (t % 2 == 0), expQ[t]);
            end
            if (t == 3) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            tick();
        end
        tick();
        assertCount++;
        if (busy !== 1'b0 || q !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL tie_idle: got busy=%b q=%b want 0 0000", busy, q);
        end
    endtask

    task automatic test_ops();
        logic [1:0] ops  [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
        logic       expB [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 5; t++) begin
            req_a = 1'b1; op_a = ops[t]; idx_a = 2'd3;
            tick();
            op_a = ~ops[t]; idx_a = 2'd0;
            tick();
            assertCount++;
            if (q !== {expB[t], 3'b000} || ack_a !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL ops_step%0d: got q=%b ack_a=%b want %b 1", t, q, ack_a, {expB[t], 3'b000});
            end
            req_a = 1'b0;
            tick();
        end
    endtask

    task automatic test_error();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        req_a = 1'b1; op_a = 2'b10; idx_a = 2'd0;
        tick(); tick();
        req_a = 1'b0;
        tick();
        req_b = 1'b1; op_b = 2'b10; idx_b = 2'd3;
        tick();
        assertCount++;
        if (busy3 !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL err_busy3: got %b want 1", busy3);
        end
        tick();
        assertCount++;
        if (ack_b3 !== 1'b1 || ack_a3 !== 1'b0 || err3 !== 1'b1 || q3 !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL err_oob: got ack=%b%b err=%b q=%b want 01 1 001", ack_a3, ack_b3, err3, q3);
        end
        assertCount++;
        if (err !== 1'b0 || q !== 4'b1001 || ack_b !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL err_inrange: got err=%b q=%b ack_b=%b want 0 1001 1", err, q, ack_b);
        end
        assertCount++;
        if (disp3 !== 7'b1111001) begin
            failCount++;
            $display("[TB] FAIL err_disp3: got %b want 1111001", disp3);
        end
        req_b = 1'b0;
        tick();
        assertCount++;
        if (err3 !== 1'b0 || ack_b3 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL err_clear: got err=%b ack_b=%b want 0 0", err3, ack_b3);
        end
    endtask

    task automatic test_override();
        req_a = 1'b1; op_a = 2'b10; idx_a = 2'd0;
        tick();
        clr_all = 1'b1; set_all = 1'b1;
        tick();
        assertCount++;
        if (q !== 4'b0000 || ack_a !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL override_apply: got q=%b ack_a=%b want 0000 1", q, ack_a);
        end
        clr_all = 1'b0; set_all = 1'b0; req_a = 1'b0;
        tick();
        set_all = 1'b1;
        tick();
        set_all = 1'b0;
        assertCount++;
        if (q !== 4'b1111 || disp !== 7'b0001110 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL override_set: got q=%b disp=%b busy=%b want 1111 0001110 0", q, disp, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_tie();
        test_ops();
        test_error();
        test_override();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
